// File: rtl/a1_stim_pkg.sv
// Shared types and constants for the a1 stimulus sequencer.
package a1_stim_pkg;

  localparam int unsigned NSTEP = 8;
  localparam logic [2:0]  LAST_IDX = 3'(NSTEP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // {A1,A0} per step, step 0 in the least significant pair.
  localparam logic [2*NSTEP-1:0] PATTERN = {
    2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00
  };

  function automatic logic [1:0] step_pattern(input logic [2:0] idx);
    return PATTERN[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/a1_edge_det.sv
// Registers a level input once and flags its rising edge for one cycle.
module a1_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_q    <= i_d;
      r_prev <= r_q;
    end
  end

  assign o_rise = r_q & ~r_prev;

endmodule

// File: rtl/a1_stim_seq.sv
// Steps a1's A0/A1/A2 through the 8-entry board pattern, DIV cycles per step,
// with run / pause / single-step / optional looping control.
module a1_stim_seq
  import a1_stim_pkg::*;
#(
  parameter int unsigned DIV  = 50000000,
  parameter bit          LOOP = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       STEP,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic [2:0] IDX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [2:0]      r_idx;
  logic [2:0]      w_idx_nxt;
  logic [DW-1:0]   r_div;
  logic [DW-1:0]   w_div_nxt;
  logic [1:0]      r_ab;
  logic [1:0]      w_ab_nxt;
  logic            r_a2;
  logic            w_a2_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_start;
  logic            w_step;
  logic            w_tick;
  logic            w_adv;

  a1_edge_det u_start_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (START),
    .o_rise (w_start)
  );

  a1_edge_det u_step_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (STEP),
    .o_rise (w_step)
  );

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_div   <= '0;
      r_ab    <= '0;
      r_a2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_div   <= w_div_nxt;
      r_ab    <= w_ab_nxt;
      r_a2    <= w_a2_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // PAUSE is tested before the tick, so a coincident tick is dropped and the
  // divider stays parked at DIV-1 until the sequence resumes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_adv       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_start) begin
          w_state_nxt = PAUSE ? ST_HOLD : ST_RUN;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end else if (PAUSE) begin
          w_state_nxt = ST_HOLD;
        end else if (w_tick) begin
          w_adv = 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_start) begin
          w_state_nxt = PAUSE ? ST_HOLD : ST_RUN;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end else if (!PAUSE) begin
          w_state_nxt = ST_RUN;
        end else if (w_step) begin
          w_adv = 1'b1;
        end
      end
      default: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
          w_div_nxt   = '0;
        end
      end
    endcase

    if (w_adv) begin
      w_div_nxt = '0;
      if (r_idx != LAST_IDX) begin
        w_idx_nxt = r_idx + 3'd1;
      end else if (LOOP) begin
        w_idx_nxt = '0;
      end else begin
        w_state_nxt = ST_DONE;
      end
    end
  end

  // Outputs are decoded from the next state so they register alongside IDX.
  always_comb begin
    w_ab_nxt   = '0;
    w_a2_nxt   = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN, ST_HOLD: begin
        w_ab_nxt   = step_pattern(w_idx_nxt);
        w_a2_nxt   = w_idx_nxt[0];
        w_busy_nxt = 1'b1;
      end
      ST_DONE: begin
        w_ab_nxt   = step_pattern(w_idx_nxt);
        w_a2_nxt   = w_idx_nxt[0];
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign A0   = r_ab[0];
  assign A1   = r_ab[1];
  assign A2   = r_a2;
  assign IDX  = r_idx;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_a1_stim_seq.sv
// Drives two sequencers (LOOP=0 and LOOP=1) with directed and random
// control traffic and compares every cycle against a step-level model.
module tb_a1_stim_seq;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;

  logic       a0_s, a1_s, a2_s, busy_s, done_s;
  logic [2:0] idx_s;
  logic       a0_l, a1_l, a2_l, busy_l, done_l;
  logic [2:0] idx_l;

  always #5 clk = ~clk;

  a1_stim_seq #(.DIV(DIV), .LOOP(1'b0)) u_dut_single (
    .CLK(clk), .RST(rst), .START(start), .PAUSE(pause), .STEP(step),
    .A0(a0_s), .A1(a1_s), .A2(a2_s), .IDX(idx_s), .BUSY(busy_s), .DONE(done_s)
  );

  a1_stim_seq #(.DIV(DIV), .LOOP(1'b1)) u_dut_loop (
    .CLK(clk), .RST(rst), .START(start), .PAUSE(pause), .STEP(step),
    .A0(a0_l), .A1(a1_l), .A2(a2_l), .IDX(idx_l), .BUSY(busy_l), .DONE(done_l)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {A1,A0} per step straight from the board pattern table.
  localparam logic [1:0] AB [8] = '{2'b00, 2'b01, 2'b10, 2'b00,
                                    2'b11, 2'b10, 2'b11, 2'b01};

  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  typedef struct {
    mode_t mode;
    int    idx;
    int    cnt;   // cycles already spent in the current step
  } model_t;

  localparam model_t MODEL_RESET = '{M_IDLE, 0, 0};

  model_t ms = MODEL_RESET;
  model_t ml = MODEL_RESET;
  bit start_h1 = 0, start_h2 = 0, step_h1 = 0, step_h2 = 0;

  function automatic model_t model_next(model_t m, bit loop, bit start_evt,
                                        bit p, bit step_evt);
    model_t n = m;
    bit     go_next = 0;
    if (start_evt) begin
      n.idx  = 0;
      n.cnt  = 0;
      n.mode = ((m.mode == M_RUN || m.mode == M_HOLD) && p) ? M_HOLD : M_RUN;
      return n;
    end
    if (m.mode == M_RUN) begin
      if (p) n.mode = M_HOLD;
      else if (m.cnt + 1 == int'(DIV)) go_next = 1;
      else n.cnt = m.cnt + 1;
    end else if (m.mode == M_HOLD) begin
      if (!p) n.mode = M_RUN;
      else if (step_evt) go_next = 1;
    end
    if (go_next) begin
      n.cnt = 0;
      if (m.idx == 7 && !loop) n.mode = M_DONE;
      else n.idx = (m.idx + 1) % 8;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_out(model_t m);
    logic [2:0] i3;
    if (m.mode == M_IDLE) return 8'h00;
    i3 = 3'(m.idx);
    return {i3, i3[0], AB[m.idx], (m.mode == M_RUN || m.mode == M_HOLD),
            (m.mode == M_DONE)};
  endfunction

  function automatic logic [7:0] got_s();
    return {idx_s, a2_s, a1_s, a0_s, busy_s, done_s};
  endfunction

  function automatic logic [7:0] got_l();
    return {idx_l, a2_l, a1_l, a0_l, busy_l, done_l};
  endfunction

  task automatic model_reset();
    ms = MODEL_RESET;
    ml = MODEL_RESET;
    start_h1 = 0; start_h2 = 0; step_h1 = 0; step_h2 = 0;
  endtask

  // Input edges are acted on at the second clock after the level first appears.
  task automatic cycle();
    bit s_evt, st_evt;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s_evt  = start_h1 && !start_h2;
      st_evt = step_h1 && !step_h2;
      ms = model_next(ms, 1'b0, s_evt, pause, st_evt);
      ml = model_next(ml, 1'b1, s_evt, pause, st_evt);
      start_h2 = start_h1; start_h1 = start;
      step_h2  = step_h1;  step_h1  = step;
    end
    #1;
    check("single", got_s(), exp_out(ms));
    check("loop", got_l(), exp_out(ml));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) cycle();
    check("reset_single", got_s(), 8'h00);
    rst = 1'b0;
    repeat (2) cycle();

    // Full pass: single stops in DONE, looping one keeps running for 3 laps.
    pulse_start();
    repeat (1 + 32 * 3) cycle();
    check("done_hold", got_s(), {3'd7, 3'b101, 1'b0, 1'b1});
    check("loop_busy", {6'd0, busy_l, done_l}, 8'b10);

    // Pause at step 2 / count 1, single-step, then release.
    pulse_start();
    for (int k = 0; k < 100 && !(ms.mode == M_RUN && ms.idx == 2 && ms.cnt == 1); k++)
      cycle();
    check("reach_idx2", {5'd0, idx_s}, 8'd2);
    pause = 1'b1;
    repeat (20) cycle();
    check("paused_idx2", {5'd0, idx_s}, 8'd2);
    step = 1'b1;
    cycle();
    step = 1'b0;
    repeat (3) cycle();
    check("stepped_idx3", {5'd0, idx_s}, 8'd3);
    pause = 1'b0;
    repeat (12) cycle();

    // Held START in IDLE gives one restart; a second START mid-run restarts.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    start = 1'b1;
    repeat (10) cycle();
    start = 1'b0;
    for (int k = 0; k < 100 && !(ms.mode == M_RUN && ms.idx == 5); k++)
      cycle();
    check("reach_idx5", {5'd0, idx_s}, 8'd5);
    pulse_start();
    repeat (8) cycle();

    // Asynchronous reset between edges at step 4.
    for (int k = 0; k < 100 && !(ms.mode == M_RUN && ms.idx == 4); k++)
      cycle();
    check("reach_idx4", {5'd0, idx_s}, 8'd4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_single", got_s(), 8'h00);
    check("async_rst_loop", got_l(), 8'h00);
    cycle();
    rst = 1'b0;
    repeat (20) cycle();
    check("idle_after_rst", got_s(), 8'h00);

    // PAUSE rising on the same cycle as the step-6 tick.
    pulse_start();
    for (int k = 0; k < 100 && !(ms.mode == M_RUN && ms.idx == 6 && ms.cnt + 1 == int'(DIV)); k++)
      cycle();
    pause = 1'b1;
    cycle();
    check("pause_beats_tick", {5'd0, idx_s}, 8'd6);
    repeat (5) cycle();
    pause = 1'b0;
    repeat (3) cycle();
    check("resume_idx7", {5'd0, idx_s}, 8'd7);

    // Random control traffic.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      step  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
